rr_arb_4_1: RTL

//  Round-robin arbiter and output register stage for four WIDTH-bit request

---
 rtl/rr_arb_pkg.sv | 8 +
 rtl/rr_pick_4.sv | 32 +++
 rtl/rr_arb_4_1.sv | 66 ++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared channel count and channel-index type for the 4:1 round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_CH = 4;

  typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: first valid channel at or after ptr, wrapping mod 4.
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_CH-1:0] vld,
  input  ch_idx_t         ptr,
  output logic            any,
  output ch_idx_t         idx
);

  logic [N_CH-1:0] rot;
  ch_idx_t         off;
  ch_idx_t         src;

  // Rotate so that bit 0 is the ptr channel, then take the lowest set bit.
  always_comb begin
    rot = '0;
    off = '0;
    src = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      src    = ptr + ch_idx_t'(k);
      rot[k] = vld[src];
    end
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      if (rot[k]) off = ch_idx_t'(k);
    end
  end

  assign any = |vld;
  assign idx = ptr + off;

endmodule

// File: rtl/rr_arb_4_1.sv
// Round-robin arbiter feeding a single registered output word with valid/ready.
module rr_arb_4_1
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_vld,
  input  logic [WIDTH-1:0] in_d0,
  input  logic [WIDTH-1:0] in_d1,
  input  logic [WIDTH-1:0] in_d2,
  input  logic [WIDTH-1:0] in_d3,
  output logic [N_CH-1:0]  in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output ch_idx_t          out_sel,
  input  logic             out_rdy
);

  ch_idx_t          ptr;
  logic             any_c;
  ch_idx_t          idx_c;
  logic             can_load_c;
  logic             load_c;
  logic [WIDTH-1:0] sel_data_c;

  rr_pick_4 u_pick (
    .vld (in_vld),
    .ptr (ptr),
    .any (any_c),
    .idx (idx_c)
  );

  assign can_load_c = !out_vld || out_rdy;
  assign load_c     = any_c && can_load_c;
  assign in_rdy     = load_c ? (N_CH'(1) << idx_c) : '0;

  // Select only the granted word so unused channels never reach the register.
  always_comb begin
    sel_data_c = '0;
    case (idx_c)
      2'd0:    sel_data_c = in_d0;
      2'd1:    sel_data_c = in_d1;
      2'd2:    sel_data_c = in_d2;
      default: sel_data_c = in_d3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sel  <= '0;
    end else if (load_c) begin
      ptr      <= idx_c + ch_idx_t'(1);
      out_vld  <= 1'b1;
      out_data <= sel_data_c;
      out_sel  <= idx_c;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule
